store_checker: RTL and testbench



---
 rtl/store_checker_pkg.sv | 29 ++
 rtl/store_checker_if.sv | 12 +
 rtl/store_checker_run_timer.sv | 31 +++
 rtl/store_checker.sv | 138 +++++++++++++
 tb/tb_store_checker.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/store_checker_pkg.sv
// Shared types and helpers for the store completion checker.
package store_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DATA    = 2'b01,
    ERR_ORDER   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;

  // Priority encoder: index of the lowest set bit (0 when none set).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [15:0] v);
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/store_checker_if.sv
// Data-memory write port of the computer, as seen by the checker.
interface store_checker_if #(
  parameter int unsigned N = 32,
  parameter int unsigned A = 32
);
  logic         memwrite;
  logic [A-1:0] dataadr;
  logic [N-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/store_checker_run_timer.sv
// Saturating RUN-cycle counter with synchronous clear and timeout compare.
module run_timer
  import store_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign timeout_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/store_checker.sv
// Completion checker: snoops data-memory stores and reports PASS once every
// expected (address,data) store has been seen, FAIL on bad data/order/timeout.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned A       = 32,
  parameter int unsigned NCHK    = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned ORDERED = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  store_checker_if.slave     mem,
  input  logic [NCHK*A-1:0]  exp_addr,
  input  logic [NCHK*N-1:0]  exp_data,
  output logic [NCHK-1:0]    hit_mask,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         err_code,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [CNT_W-1:0]   cycles
);

  state_t                     state_q, state_d;
  err_t                       err_q, err_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NCHK-1:0]            hit_q, hit_d;
  logic [NCHK-1:0][A-1:0]     exp_addr_q;
  logic [NCHK-1:0][N-1:0]     exp_data_q;

  logic [NCHK-1:0]            addr_eq, data_eq, unhit_m, hitm, cand_oh, nxt_oh;
  logic                       load, tmr_clr, tmr_en, tmr_to;

  always_comb begin
    addr_eq = '0;
    data_eq = '0;
    for (int unsigned i = 0; i < NCHK; i++) begin
      addr_eq[i] = (exp_addr_q[i] == mem.dataadr);
      data_eq[i] = (exp_data_q[i] == mem.writedata);
    end
  end

  // Lowest unhit matching entry is the candidate; lowest unhit entry overall
  // is the next one expected in ordered mode.
  assign unhit_m = addr_eq & ~hit_q;
  assign hitm    = addr_eq & hit_q;
  assign cand_oh = unhit_m & (~unhit_m + NCHK'(1));
  assign nxt_oh  = ~hit_q & (hit_q + NCHK'(1));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    load    = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if (start) begin
      state_d = RUN;
      err_d   = ERR_NONE;
      idx_d   = '0;
      hit_d   = '0;
      load    = 1'b1;
      tmr_clr = 1'b1;
    end else if (state_q == RUN) begin
      if (mem.memwrite) begin
        if (|unhit_m) begin
          if (!(|(cand_oh & data_eq))) begin
            state_d = FAIL;
            err_d   = ERR_DATA;
            idx_d   = lowest_idx(16'(unhit_m));
          end else if (ORDERED != 0 && cand_oh != nxt_oh) begin
            state_d = FAIL;
            err_d   = ERR_ORDER;
            idx_d   = lowest_idx(16'(unhit_m));
          end else begin
            hit_d = hit_q | cand_oh;
          end
        end else if (|hitm && !(|(hitm & data_eq))) begin
          state_d = FAIL;
          err_d   = ERR_DATA;
          idx_d   = lowest_idx(16'(hitm));
        end
      end
      // Completion is checked before timeout so a final hit on the last cycle passes.
      if (state_d == RUN) begin
        if (&hit_d) begin
          state_d = PASS;
        end else if (tmr_to) begin
          state_d = FAIL;
          err_d   = ERR_TIMEOUT;
          idx_d   = '0;
        end
      end
      tmr_en = (state_d == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      err_q      <= ERR_NONE;
      idx_q      <= '0;
      hit_q      <= '0;
      exp_addr_q <= '0;
      exp_data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      if (load) begin
        exp_addr_q <= exp_addr;
        exp_data_q <= exp_data;
      end
    end
  end

  run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .cnt_o    (cycles),
    .timeout_o(tmr_to)
  );

  assign hit_mask = hit_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == PASS) || (state_q == FAIL);
  assign pass     = (state_q == PASS);
  assign err_code = err_q;
  assign fail_idx = idx_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench: unordered and ordered checkers share one snooped store bus.
module tb_store_checker;
  import store_checker_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_u = 1'b0;
  logic        start_o = 1'b0;
  logic [63:0] exp_addr;
  logic [63:0] exp_data;

  logic [1:0]  hit_u, hit_o;
  logic        busy_u, busy_o, done_u, done_o, pass_u, pass_o;
  logic [1:0]  err_u, err_o;
  logic [3:0]  fidx_u, fidx_o;
  logic [15:0] cyc_u, cyc_o;

  int errors = 0;
  int checks = 0;

  store_checker_if #(.N(32), .A(32)) bus ();

  store_checker #(.N(32), .A(32), .NCHK(2), .TIMEOUT(64), .ORDERED(0)) u_unord (
    .clk(clk), .reset(reset), .start(start_u), .mem(bus),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .hit_mask(hit_u), .busy(busy_u), .done(done_u), .pass(pass_u),
    .err_code(err_u), .fail_idx(fidx_u), .cycles(cyc_u)
  );

  store_checker #(.N(32), .A(32), .NCHK(2), .TIMEOUT(64), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .start(start_o), .mem(bus),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .hit_mask(hit_o), .busy(busy_o), .done(done_o), .pass(pass_o),
    .err_code(err_o), .fail_idx(fidx_o), .cycles(cyc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  task automatic go_u();
    start_u = 1'b1;
    tick();
    start_u = 1'b0;
  endtask

  task automatic go_o();
    start_o = 1'b1;
    tick();
    start_o = 1'b0;
  endtask

  task automatic set_exp();
    exp_addr = {32'd22, 32'd21};
    exp_data = {32'h7, 32'h96};
  endtask

  initial begin
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    set_exp();
    #2 reset = 1'b0;
    #2;
    check("rst_hit",  32'(hit_u), 0);
    check("rst_busy", 32'(busy_u), 0);
    check("rst_done", 32'(done_u), 0);
    check("rst_pass", 32'(pass_u), 0);
    check("rst_err",  32'(err_u), 0);
    check("rst_fidx", 32'(fidx_u), 0);
    check("rst_cyc",  32'(cyc_u), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Unordered: out-of-order completion, ignored stores, late input changes.
    go_u();
    check("start_busy", 32'(busy_u), 1);
    check("start_cyc",  32'(cyc_u), 0);
    exp_addr = '0;
    exp_data = '1;
    store(22, 32'h7);
    check("hit22", 32'(hit_u), 2);
    store(5, 32'h1234);
    check("unlisted", 32'(hit_u), 2);
    store(22, 32'h7);
    check("repeat_same", 32'(busy_u), 1);
    bus.dataadr = 21; bus.writedata = 32'h95;
    tick();
    check("nowrite_busy", 32'(busy_u), 1);
    store(21, 32'h96);
    check("both_hit",  32'(hit_u), 3);
    check("pass",      32'(pass_u), 1);
    check("pass_done", 32'(done_u), 1);
    check("pass_err",  32'(err_u), 0);
    check("pass_cyc",  32'(cyc_u), 4);
    store(21, 32'h95);
    check("pass_sticky", 32'(pass_u), 1);
    set_exp();

    // Data mismatch on first store.
    go_u();
    store(21, 32'h95);
    check("mis_done", 32'(done_u), 1);
    check("mis_pass", 32'(pass_u), 0);
    check("mis_err",  32'(err_u), 1);
    check("mis_idx",  32'(fidx_u), 0);
    check("mis_hit",  32'(hit_u), 0);

    // Re-store to an already-hit address with different data.
    go_u();
    store(21, 32'h96);
    store(21, 32'h96);
    check("rehit_busy", 32'(busy_u), 1);
    store(21, 32'h11);
    check("rehit_err", 32'(err_u), 1);
    check("rehit_idx", 32'(fidx_u), 0);

    // Timeout.
    go_u();
    repeat (63) tick();
    check("to_pre_cyc",  32'(cyc_u), 63);
    check("to_pre_busy", 32'(busy_u), 1);
    tick();
    check("to_done", 32'(done_u), 1);
    check("to_err",  32'(err_u), 3);
    check("to_idx",  32'(fidx_u), 0);
    check("to_cyc",  32'(cyc_u), 63);

    // Restart, final hit exactly on the timeout cycle.
    go_u();
    check("rs_cyc",  32'(cyc_u), 0);
    check("rs_busy", 32'(busy_u), 1);
    check("rs_err",  32'(err_u), 0);
    store(22, 32'h7);
    repeat (62) tick();
    check("last_cyc", 32'(cyc_u), 63);
    store(21, 32'h96);
    check("last_pass", 32'(pass_u), 1);
    check("last_err",  32'(err_u), 0);

    // Ordered: wrong order.
    go_o();
    store(22, 32'h7);
    check("ord_done", 32'(done_o), 1);
    check("ord_err",  32'(err_o), 2);
    check("ord_idx",  32'(fidx_o), 1);
    check("ord_hit",  32'(hit_o), 0);
    check("ord_u_idle", 32'(pass_u), 1);

    // Ordered: restart mid-RUN clears progress, then correct order passes.
    go_o();
    store(21, 32'h96);
    check("ord_h1", 32'(hit_o), 1);
    go_o();
    check("ord_rs_hit", 32'(hit_o), 0);
    check("ord_rs_cyc", 32'(cyc_o), 0);
    store(21, 32'h96);
    store(22, 32'h7);
    check("ord_pass", 32'(pass_o), 1);

    // Reset mid-RUN after one hit.
    go_u();
    store(21, 32'h96);
    check("pre_rst_hit", 32'(hit_u), 1);
    reset = 1'b0;
    #1;
    check("arst_hit",  32'(hit_u), 0);
    check("arst_busy", 32'(busy_u), 0);
    check("arst_done", 32'(done_u), 0);
    check("arst_cyc",  32'(cyc_u), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    store(22, 32'h7);
    check("idle_ignore", 32'(hit_u), 0);
    check("idle_busy",   32'(busy_u), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
